sprite_oam_scanner: RTL and testbench

Per-line OAM search stage for the sprite pipeline. It walks all 40 OAM entries in 80 clocks at the start of each line and tests each entry's Y against the current line number. It loads the first ten hits, in OAM order, into the ten sprite slots of the downstream sprite X matcher bank: X byte, OAM index, and row-within-sprite. It also clears the slot-valid latches at line start, so the X matchers never compare against stale sprites.

---
 rtl/sprite_oam_scanner.sv | 121 ++++++++++++
 tb/tb_sprite_oam_scanner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_oam_scanner.sv
// Per-line OAM search: walks every OAM entry, compares Y against the latched line,
// and loads the first NUM_SLOTS hits into the sprite X matcher bank.
module sprite_oam_scanner #(
  parameter int unsigned NUM_SLOTS   = 10,
  parameter int unsigned OAM_ENTRIES = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start,
  input  logic [7:0] ly,
  input  logic       obj_size,
  output logic [5:0] oam_addr,
  output logic       oam_rd,
  input  logic [7:0] oam_y,
  input  logic [7:0] oam_x,
  output logic       slot_clear,
  output logic       store_we,
  output logic [3:0] store_slot,
  output logic [7:0] store_x,
  output logic [5:0] store_idx,
  output logic [3:0] store_row,
  output logic       scanning,
  output logic       scan_done,
  output logic [3:0] sprite_count
);

  typedef enum logic [1:0] {StIdle, StRead, StCmp, StFin} state_t;

  state_t     state_q, state_d;
  logic [5:0] n_q, n_d;
  logic [7:0] ly_q;
  logic [3:0] count_q;
  logic       slot_clear_q;
  logic       store_we_q;
  logic [3:0] store_slot_q;
  logic [7:0] store_x_q;
  logic [5:0] store_idx_q;
  logic [3:0] store_row_q;

  logic [7:0] row;
  logic [7:0] height;
  logic       hit;
  logic       do_store;
  logic       last_entry;

  // Sprite Y is biased by 16, so the row offset is taken modulo 256.
  assign row        = ly_q + 8'd16 - oam_y;
  assign height     = obj_size ? 8'd16 : 8'd8;
  assign hit        = (state_q == StCmp) && (row < height);
  assign last_entry = (n_q == 6'(OAM_ENTRIES - 1));
  // A restart in the same clock suppresses the store from the aborted compare.
  assign do_store   = hit && (count_q < 4'(NUM_SLOTS)) && !line_start;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      StIdle: ;
      StRead: state_d = StCmp;
      StCmp: begin
        if (last_entry) begin
          state_d = StFin;
        end else begin
          state_d = StRead;
          n_d     = n_q + 6'd1;
        end
      end
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (line_start) begin
      state_d = StRead;
      n_d     = 6'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      n_q          <= 6'd0;
      ly_q         <= 8'd0;
      count_q      <= 4'd0;
      slot_clear_q <= 1'b0;
      store_we_q   <= 1'b0;
      store_slot_q <= 4'd0;
      store_x_q    <= 8'd0;
      store_idx_q  <= 6'd0;
      store_row_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      slot_clear_q <= line_start;
      store_we_q   <= do_store;
      if (line_start) begin
        ly_q    <= ly;
        count_q <= 4'd0;
      end else if (do_store) begin
        count_q <= count_q + 4'd1;
      end
      if (do_store) begin
        store_slot_q <= count_q;
        store_x_q    <= oam_x;
        store_idx_q  <= n_q;
        store_row_q  <= row[3:0];
      end
    end
  end

  assign oam_addr     = n_q;
  assign oam_rd       = (state_q == StRead);
  assign scanning     = (state_q == StRead) || (state_q == StCmp);
  assign scan_done    = (state_q == StFin);
  assign slot_clear   = slot_clear_q;
  assign store_we     = store_we_q;
  assign store_slot   = store_slot_q;
  assign store_x      = store_x_q;
  assign store_idx    = store_idx_q;
  assign store_row    = store_row_q;
  assign sprite_count = count_q;

endmodule

// File: tb/tb_sprite_oam_scanner.sv
// Scoreboard bench for sprite_oam_scanner: a behavioural OAM answers reads, and
// expected slot stores are queued per scan and popped as store_we pulses appear.
module tb_sprite_oam_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_start;
  logic [7:0] ly;
  logic       obj_size;
  logic [5:0] oam_addr;
  logic       oam_rd;
  logic [7:0] oam_y;
  logic [7:0] oam_x;
  logic       slot_clear;
  logic       store_we;
  logic [3:0] store_slot;
  logic [7:0] store_x;
  logic [5:0] store_idx;
  logic [3:0] store_row;
  logic       scanning;
  logic       scan_done;
  logic [3:0] sprite_count;

  sprite_oam_scanner #(.NUM_SLOTS(10), .OAM_ENTRIES(40)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .ly(ly), .obj_size(obj_size),
    .oam_addr(oam_addr), .oam_rd(oam_rd), .oam_y(oam_y), .oam_x(oam_x),
    .slot_clear(slot_clear), .store_we(store_we), .store_slot(store_slot),
    .store_x(store_x), .store_idx(store_idx), .store_row(store_row),
    .scanning(scanning), .scan_done(scan_done), .sprite_count(sprite_count)
  );

  always #5 clk = ~clk;

  logic [7:0] ymem [40];
  logic [7:0] xmem [40];

  always @(posedge clk) begin
    if (oam_rd) begin
      oam_y <= ymem[oam_addr];
      oam_x <= xmem[oam_addr];
    end
  end

  typedef struct {
    int cyc;
    int slot;
    int x;
    int idx;
    int row;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_count;
  int   done_cyc;
  int   start_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_model(input int base, input int l, input logic sz);
    int cnt = 0;
    q.delete();
    for (int n = 0; n < 40; n++) begin
      int r;
      r = (l + 16 - int'(ymem[n]) + 512) % 256;
      if (r < (sz ? 16 : 8) && cnt < 10) begin
        q.push_back('{cyc: base + 3 + 2 * n, slot: cnt, x: int'(xmem[n]), idx: n, row: r});
        cnt++;
      end
    end
    exp_count = cnt;
    done_cyc  = base + 81;
    start_cyc = base;
  endtask

  task automatic run_scan(input logic [7:0] l, input logic sz, input int abort_at);
    int c;
    exp_t e;
    @(negedge clk);
    ly = l;
    obj_size = sz;
    line_start = 1'b1;
    push_model(0, int'(l), sz);
    @(negedge clk);
    line_start = 1'b0;
    c = 1;
    while (c <= done_cyc + 1) begin
      if (c == start_cyc + 1) begin
        check("slot_clear", slot_clear, 1);
        check("scanning_start", scanning, 1);
        check("count_start", sprite_count, 0);
        check("addr_start", oam_addr, 0);
        check("rd_start", oam_rd, 1);
      end
      if (c == start_cyc + 79) begin
        check("addr_last", oam_addr, 39);
        check("rd_last", oam_rd, 1);
      end
      if (store_we) begin
        if (q.size() == 0) begin
          check("extra_store_cycle", c, 0);
        end else begin
          e = q.pop_front();
          check("store_cycle", c, e.cyc);
          check("store_slot", store_slot, e.slot);
          check("store_x", store_x, e.x);
          check("store_idx", store_idx, e.idx);
          check("store_row", store_row, e.row);
          check("store_count", sprite_count, e.slot + 1);
        end
      end
      if (scan_done || c == done_cyc) check("scan_done_at_expected", scan_done, c == done_cyc);
      if (c == done_cyc + 1) begin
        check("scanning_end", scanning, 0);
        check("count_end", sprite_count, exp_count);
        check("missing_stores", q.size(), 0);
      end
      if (c == abort_at) begin
        line_start = 1'b1;
        push_model(c, int'(l), sz);
      end
      @(negedge clk);
      line_start = 1'b0;
      c++;
    end
  endtask

  task automatic fill(input logic [7:0] y_all);
    for (int n = 0; n < 40; n++) begin
      ymem[n] = y_all;
      xmem[n] = 8'(3 * n + 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    line_start = 1'b0;
    ly = 8'd0;
    obj_size = 1'b0;
    oam_y = 8'd0;
    oam_x = 8'd0;
    fill(8'd0);
    repeat (3) @(negedge clk);
    check("rst_scanning", scanning, 0);
    check("rst_done", scan_done, 0);
    check("rst_clear", slot_clear, 0);
    check("rst_we", store_we, 0);
    check("rst_fields", {store_slot, store_x, store_idx, store_row}, 0);
    check("rst_rd", oam_rd, 0);
    check("rst_addr", oam_addr, 0);
    check("rst_count", sprite_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Overflow: every entry hits, only the first ten are stored.
    for (int n = 0; n < 40; n++) begin
      ymem[n] = 8'd16;
      xmem[n] = 8'(8 + n);
    end
    run_scan(8'd0, 1'b0, 0);

    // Height boundaries around entry 5.
    fill(8'd0);
    ymem[5] = 8'd16;
    run_scan(8'd7, 1'b0, 0);
    run_scan(8'd8, 1'b0, 0);
    run_scan(8'd15, 1'b1, 0);
    run_scan(8'd16, 1'b1, 0);

    // Wrap arithmetic.
    fill(8'd0);
    ymem[3] = 8'd160;
    run_scan(8'd144, 1'b0, 0);
    fill(8'd0);
    run_scan(8'd0, 1'b0, 0);
    run_scan(8'd0, 1'b1, 0);
    fill(8'd200);
    run_scan(8'd0, 1'b1, 0);

    // Restart mid-scan, then restart coinciding with the done pulse.
    fill(8'd0);
    ymem[0]  = 8'd16;
    ymem[30] = 8'd16;
    run_scan(8'd0, 1'b0, 40);
    run_scan(8'd0, 1'b0, 81);

    // Reset mid-scan with stores already made.
    fill(8'd16);
    @(negedge clk);
    ly = 8'd0;
    obj_size = 1'b0;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c == 29) check("count_before_reset", sprite_count, 10);
      if (c == 30) begin
        reset = 1'b1;
        #1;
        check("reset_scanning", scanning, 0);
        check("reset_we", store_we, 0);
        check("reset_count", sprite_count, 0);
      end
      if (c == 31) reset = 1'b0;
      if (c > 30 && scan_done) check("done_after_reset", scan_done, 0);
      if (c > 30 && store_we) check("store_after_reset", store_we, 0);
      if (c == 100) check("idle_after_reset", {scanning, oam_rd}, 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
